// File: rtl/cpu_bus_responder_if.sv
// rtl/cpu_bus_responder_if.sv - CPU-side request/response bundle of the bus responder
interface cpu_bus_responder_if;
  logic [2:0]  bus_op;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [1:0]  t_phase;
  logic        m_done;
  logic [7:0]  rdata;
  logic        rdata_valid;
  logic [7:0]  opcode;
  logic        opcode_valid;
  logic        opcode_cb;

  modport master (
    output bus_op, addr, wdata,
    input  t_phase, m_done, rdata, rdata_valid, opcode, opcode_valid, opcode_cb
  );

  modport slave (
    input  bus_op, addr, wdata,
    output t_phase, m_done, rdata, rdata_valid, opcode, opcode_valid, opcode_cb
  );
endinterface

// File: rtl/cpu_bus_responder.sv
// rtl/cpu_bus_responder.sv - T1..T4 sequenced bus target with local HRAM/IE and external forwarding
package cpu_pkg;
  typedef enum logic [2:0] {
    BUS_IDLE  = 3'd0,
    BUS_IF    = 3'd1,
    BUS_WRITE = 3'd2,
    BUS_READ  = 3'd3,
    BUS_IF_CB = 3'd4
  } bus_opcode_t;
endpackage

module cpu_bus_responder #(
  parameter int MAX_WAIT   = 15,
  parameter int HRAM_DEPTH = 127
) (
  input  logic                 clk,
  input  logic                 rst,
  cpu_bus_responder_if.slave   cpu,
  input  logic                 dma_active,
  output logic [7:0]           ie_reg,
  output logic [15:0]          ext_addr,
  output logic [7:0]           ext_wdata,
  output logic                 ext_rd,
  output logic                 ext_wr,
  input  logic [7:0]           ext_rdata,
  input  logic                 ext_ready,
  output logic                 bus_err
);
  import cpu_pkg::*;

  typedef enum logic [1:0] {T1 = 2'd0, T2 = 2'd1, T3 = 2'd2, T4 = 2'd3} phase_t;

  localparam int              HRAM_AW   = (HRAM_DEPTH > 1) ? $clog2(HRAM_DEPTH) : 1;
  localparam int              SW        = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [SW-1:0]   STALL_MAX = SW'(MAX_WAIT);
  localparam logic [31:0]     HRAM_BASE = 32'h0000_FF80;
  localparam logic [31:0]     HRAM_END  = HRAM_BASE + 32'(HRAM_DEPTH);

  // Encodings outside the defined set behave as IDLE.
  function automatic bus_opcode_t norm_op(input logic [2:0] raw);
    case (raw)
      3'd1:    return BUS_IF;
      3'd2:    return BUS_WRITE;
      3'd3:    return BUS_READ;
      3'd4:    return BUS_IF_CB;
      default: return BUS_IDLE;
    endcase
  endfunction

  // 0xFFFF is always IE even if HRAM_DEPTH would reach it.
  function automatic logic in_hram(input logic [15:0] a);
    return ({16'h0000, a} >= HRAM_BASE) && ({16'h0000, a} < HRAM_END) && (a != 16'hFFFF);
  endfunction

  function automatic logic is_read(input bus_opcode_t op);
    return (op == BUS_IF) || (op == BUS_READ) || (op == BUS_IF_CB);
  endfunction

  phase_t          phase_q, phase_d;
  bus_opcode_t     op_q, op_d;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            dma_q, dma_d;
  logic [SW-1:0]   stall_q, stall_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            rdata_valid_q, rdata_valid_d;
  logic [7:0]      opcode_q, opcode_d;
  logic            opcode_valid_q, opcode_valid_d;
  logic            opcode_cb_q, opcode_cb_d;
  logic            m_done_q, m_done_d;
  logic [7:0]      ie_q, ie_d;
  logic [15:0]     ext_addr_q, ext_addr_d;
  logic [7:0]      ext_wdata_q, ext_wdata_d;
  logic            ext_rd_q, ext_rd_d;
  logic            ext_wr_q, ext_wr_d;
  logic            bus_err_q, bus_err_d;

  logic [7:0]         hram_mem [HRAM_DEPTH];
  logic               hram_we;
  logic [HRAM_AW-1:0] hram_idx;
  logic [HRAM_AW-1:0] req_idx_unused;

  bus_opcode_t req_op;
  logic        req_ext;
  logic        req_live;
  logic        acc_ie, acc_hram, acc_ext, ext_live;
  logic        leave_t3, timed_out;
  logic [7:0]  local_rdata, result;

  // Decode of the request currently presented in T1 and of the latched one.
  always_comb begin
    req_op         = norm_op(cpu.bus_op);
    req_ext        = !in_hram(cpu.addr) && (cpu.addr != 16'hFFFF);
    req_live       = (phase_q == T1) && !rst && (req_op != BUS_IDLE) && req_ext && !dma_active;
    req_idx_unused = '0;
    acc_ie         = (addr_q == 16'hFFFF);
    acc_hram       = in_hram(addr_q);
    acc_ext        = !acc_ie && !acc_hram;
    ext_live       = acc_ext && !dma_q && (op_q != BUS_IDLE);
    hram_idx       = HRAM_AW'(addr_q - 16'hFF80);
    local_rdata    = acc_ie ? ie_q : hram_mem[hram_idx];
  end

  // Phase sequencing, wait-state handling and result capture.
  always_comb begin
    phase_d        = phase_q;
    op_d           = op_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    dma_d          = dma_q;
    stall_d        = stall_q;
    rdata_d        = rdata_q;
    rdata_valid_d  = 1'b0;
    opcode_d       = opcode_q;
    opcode_valid_d = 1'b0;
    opcode_cb_d    = opcode_cb_q;
    m_done_d       = 1'b0;
    ie_d           = ie_q;
    ext_addr_d     = ext_addr_q;
    ext_wdata_d    = ext_wdata_q;
    ext_rd_d       = ext_rd_q;
    ext_wr_d       = ext_wr_q;
    bus_err_d      = bus_err_q;
    hram_we        = 1'b0;
    leave_t3       = 1'b0;
    timed_out      = 1'b0;
    result         = 8'hFF;

    case (phase_q)
      T1: begin
        phase_d = T2;
        op_d    = req_op;
        addr_d  = cpu.addr;
        wdata_d = cpu.wdata;
        dma_d   = dma_active;
        stall_d = '0;
        if (req_live) begin
          ext_addr_d = cpu.addr;
          ext_rd_d   = is_read(req_op);
          if (req_op == BUS_WRITE) ext_wdata_d = cpu.wdata;
        end
      end
      T2: begin
        phase_d  = T3;
        ext_wr_d = ext_live && (op_q == BUS_WRITE);
      end
      T3: begin
        if (ext_live && !ext_ready) begin
          if (stall_q == STALL_MAX) begin
            leave_t3  = 1'b1;
            timed_out = 1'b1;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end else begin
          leave_t3 = 1'b1;
        end

        if (leave_t3) begin
          phase_d  = T4;
          ext_rd_d = 1'b0;
          ext_wr_d = 1'b0;
          m_done_d = 1'b1;
          if (timed_out) bus_err_d = 1'b1;

          if (!acc_ext)                  result = local_rdata;
          else if (ext_live && !timed_out) result = ext_rdata;
          else                           result = 8'hFF;

          if (op_q == BUS_WRITE && !acc_ext) begin
            if (acc_ie) ie_d = wdata_q;
            else        hram_we = 1'b1;
          end

          case (op_q)
            BUS_READ: begin
              rdata_d       = result;
              rdata_valid_d = 1'b1;
            end
            BUS_IF, BUS_IF_CB: begin
              opcode_d       = result;
              opcode_valid_d = 1'b1;
              opcode_cb_d    = (op_q == BUS_IF_CB);
            end
            default: ;
          endcase
        end
      end
      default: begin
        phase_d = T1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q        <= T1;
      op_q           <= BUS_IDLE;
      addr_q         <= 16'h0000;
      wdata_q        <= 8'h00;
      dma_q          <= 1'b0;
      stall_q        <= '0;
      rdata_q        <= 8'h00;
      rdata_valid_q  <= 1'b0;
      opcode_q       <= 8'h00;
      opcode_valid_q <= 1'b0;
      opcode_cb_q    <= 1'b0;
      m_done_q       <= 1'b0;
      ie_q           <= 8'h00;
      ext_addr_q     <= 16'h0000;
      ext_wdata_q    <= 8'h00;
      ext_rd_q       <= 1'b0;
      ext_wr_q       <= 1'b0;
      bus_err_q      <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      op_q           <= op_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      dma_q          <= dma_d;
      stall_q        <= stall_d;
      rdata_q        <= rdata_d;
      rdata_valid_q  <= rdata_valid_d;
      opcode_q       <= opcode_d;
      opcode_valid_q <= opcode_valid_d;
      opcode_cb_q    <= opcode_cb_d;
      m_done_q       <= m_done_d;
      ie_q           <= ie_d;
      ext_addr_q     <= ext_addr_d;
      ext_wdata_q    <= ext_wdata_d;
      ext_rd_q       <= ext_rd_d;
      ext_wr_q       <= ext_wr_d;
      bus_err_q      <= bus_err_d;
    end
  end

  // HRAM array keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (hram_we) hram_mem[hram_idx] <= wdata_q;
  end

  // The address is presented combinationally during T1, before the request is latched.
  assign ext_addr         = req_live ? cpu.addr : ext_addr_q;
  assign ext_wdata        = (req_live && req_op == BUS_WRITE) ? cpu.wdata : ext_wdata_q;
  assign ext_rd           = ext_rd_q;
  assign ext_wr           = ext_wr_q;
  assign ie_reg           = ie_q;
  assign bus_err          = bus_err_q;
  assign cpu.t_phase      = phase_q;
  assign cpu.m_done       = m_done_q;
  assign cpu.rdata        = rdata_q;
  assign cpu.rdata_valid  = rdata_valid_q;
  assign cpu.opcode       = opcode_q;
  assign cpu.opcode_valid = opcode_valid_q;
  assign cpu.opcode_cb    = opcode_cb_q;
endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Target-side end of the CPU memory bus.
- Accepts the CPU's per-M-cycle bus_opcode_t request (IDLE/IF/WRITE/READ/IF_CB), address and write data.
- Sequences it over four T-cycles (T1..T4), serving HRAM (0xFF80-0xFFFE) and IE (0xFFFF) locally and forwarding everything else to the external memory/peripheral bus.
- Returns read data or fetched opcode plus an M-cycle-done pulse that advances the CPU's decode step.

Parameters:
- MAX_WAIT, 15, maximum T3 stall cycles on ext_ready=0 before the access is aborted
- HRAM_DEPTH, 127, HRAM bytes at 0xFF80 upward (0xFFFF is always IE)

Ports:
- clk  in  1  T-cycle clock (one clk = one T-cycle)
- rst  in  1  asynchronous, active-high reset
- bus_op  in  3  cpu_pkg::bus_opcode_t request, sampled in T1
- addr  in  16  request address, sampled in T1
- wdata  in  8  write data, sampled in T1
- t_phase  out  2  current T-cycle: 0=T1, 1=T2, 2=T3, 3=T4
- m_done  out  1  one-cycle pulse in T4; CPU advances its M-cycle on it
- rdata  out  8  READ result, valid while rdata_valid
- rdata_valid  out  1  pulse in T4 of a READ
- opcode  out  8  fetched instruction byte
- opcode_valid  out  1  pulse in T4 of IF or IF_CB
- opcode_cb  out  1  with opcode_valid: 1 when fetch was IF_CB
- ie_reg  out  8  interrupt-enable register contents
- dma_active  in  1  OAM DMA owns the external bus
- ext_addr  out  16  external bus address
- ext_wdata  out  8  external write data
- ext_rd  out  1  external read strobe
- ext_wr  out  1  external write strobe
- ext_rdata  in  8  external read data
- ext_ready  in  1  external target ready; 0 stalls T3
- bus_err  out  1  sticky: an access hit the MAX_WAIT timeout

Behaviour:
- Reset values (asynchronous, applied immediately, including mid-access):
  - t_phase=0, all pulses/strobes 0, rdata=0x00, opcode=0x00, opcode_cb=0, ie_reg=0x00, ext_addr=0x0000, ext_wdata=0x00, bus_err=0.
  - HRAM contents are not reset.
- Phase FSM T1->T2->T3->T4->T1, one clk each, free-running; IDLE M-cycles still take 4 clks and pulse m_done.
- T1 sampling:
  - Latch bus_op, addr, wdata and dma_active; request inputs are ignored in T2..T4.
  - bus_op encodings 5-7 are treated as IDLE.
- Target decode on the latched addr:
  - 0xFF80 to 0xFF80+HRAM_DEPTH-1 -> HRAM
  - 0xFFFF -> IE
  - anything else -> EXT
- EXT read (READ/IF/IF_CB):
  - ext_addr driven from T1 through T4.
  - ext_rd high in T2 and T3.
  - ext_rdata captured at the clk edge leaving T3 with ext_ready=1.
- EXT write:
  - ext_addr/ext_wdata driven from T1 through T4; ext_wr high in T3 only.
  - The write completes on the T3 edge with ext_ready=1.
- Wait states:
  - In T3 with ext_ready=0, hold T3 (strobes held) and increment a stall counter.
  - At MAX_WAIT stalls, leave T3 anyway: a read returns 0xFF, a write is dropped, bus_err is set.
  - bus_err clears only on rst.
  - Local targets never stall.
- HRAM/IE:
  - Write commits at the end of T3.
  - Read data is available in T4; IE reads return ie_reg.
  - No ext strobes for local accesses.
- DMA lock (dma_active=1 at T1):
  - EXT reads return 0xFF, EXT writes are dropped, no ext strobes.
  - HRAM/IE behave normally.
  - dma_active changes after T1 do not affect the current M-cycle.
- Result delivery, all registered and valid during T4:
  - READ -> rdata plus rdata_valid.
  - IF -> opcode, opcode_valid, opcode_cb=0.
  - IF_CB -> opcode, opcode_valid, opcode_cb=1.
  - rdata and opcode hold their values until the next delivery.
- Latency: unstalled access = 4 clks from T1 to m_done; a stall of N adds N clks; m_done is never issued twice per M-cycle.

Test Plan:
- Unstalled external read (READ, addr 0xC000, ext_rdata=0x5A, ext_ready=1) -> ext_rd high T2-T3, rdata=0x5A with rdata_valid and m_done in T4, 4 clks total.
- IF_CB at 0x0150, ext_rdata=0x37 -> opcode=0x37, opcode_valid=1, opcode_cb=1 in T4; then plain IF -> opcode_cb=0.
- HRAM/IE round trip (WRITE 0xFF80=0xA5, WRITE 0xFFFF=0x1F, READ 0xFF80) -> rdata=0xA5, ie_reg=0x1F, ext_rd/ext_wr never asserted.
- Wait states and timeout:
  - READ 0x4000 with ext_ready=0 for 3 clks -> T3 held 3 extra clks, m_done at clk 7, bus_err=0.
  - ext_ready held 0 -> after 15 stalls rdata=0xFF, bus_err=1.
- DMA lock (dma_active=1 at T1) -> READ 0x8000 returns 0xFF with no ext_rd; READ 0xFF90 returns the stored HRAM byte.
- Reset mid-access (rst asserted during T3 of an EXT write) -> ext_wr drops immediately, t_phase=0, ie_reg=0x00; after release a fresh IDLE M-cycle gives m_done 4 clks later.
